imem_loader: RTL

- Boot-time program loader that sits directly upstream of the CPU's instruction ROM.
- Receives a byte stream (valid/ready), packs it into 32-bit instruction words and writes them to consecutive word addresses of the instruction memory.
- Holds the CPU in reset until the whole image is written, then releases it so fetch starts at PC 0.
- Word-addressed, matching the CPU's PC+1 increment.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/byte_packer.sv | 42 ++++
 rtl/imem_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared state encoding and header constants for the boot loader.
// Revision : 1.0
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Word count header arrives MSB first: first byte lands at bit 8, second at bit 0.
  localparam int c_HDR_HI_LSB = 8;
  localparam int c_HDR_LO_LSB = 0;

  localparam int c_DEFAULT_TIMEOUT = 1024;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Packs four bytes big-endian into a word, pulsing o_word_valid.
// Revision : 1.0
// ============================================================================
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;
  logic        r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= 32'd0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_flush) begin
        r_cnt <= 2'd0;
      end else if (i_accept) begin
        r_word  <= {r_word[23:0], i_byte};
        r_cnt   <= r_cnt + 2'd1;
        r_valid <= (r_cnt == 2'd3);
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Streams a length-prefixed byte image into instruction memory,
//            holding the CPU in reset until the image is complete.
// Revision : 1.0
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int          c_IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [16:0] c_CAP    = 17'(2 ** ADDR_W);

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_count;
  logic [ADDR_W-1:0]   r_idx;
  logic [c_IDLE_W-1:0] r_idle;

  logic        w_accept;
  logic        w_loading;
  logic        w_timeout;
  logic        w_write;
  logic        w_last;
  logic        w_too_big;
  logic        w_restart;
  logic [15:0] w_hdr_count;
  logic [31:0] w_word;
  logic        w_word_valid;

  assign in_ready    = (r_state == ST_HDR0) || (r_state == ST_HDR1) || (r_state == ST_DATA);
  assign w_accept    = in_valid & in_ready;
  assign w_loading   = (r_state == ST_HDR1) || (r_state == ST_DATA);
  assign w_timeout   = w_loading && !w_accept && (r_idle == c_IDLE_W'(TIMEOUT - 1));
  assign w_hdr_count = {r_count[c_HDR_HI_LSB +: 8], in_data};
  assign w_too_big   = {1'b0, w_hdr_count} > c_CAP;
  assign w_write     = w_word_valid && (r_state == ST_DATA);
  assign w_last      = (r_idx == ADDR_W'(r_count - 16'd1));
  assign w_restart   = reload && ((r_state == ST_DONE) || (r_state == ST_ERR));

  byte_packer u_packer (
    .clk          (clk),
    .rst          (Rst),
    .i_flush      (r_state != ST_DATA),
    .i_accept     (w_accept && (r_state == ST_DATA)),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) r_state <= ST_HDR0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HDR0: if (w_accept) w_next = ST_HDR1;
      ST_HDR1: begin
        if (w_accept) begin
          if (w_hdr_count == 16'd0) w_next = ST_DONE;
          else if (w_too_big)       w_next = ST_ERR;
          else                      w_next = ST_DATA;
        end else if (w_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_DATA: begin
        if (w_write && w_last) w_next = ST_DONE;
        else if (w_timeout)    w_next = ST_ERR;
      end
      ST_DONE, ST_ERR: if (reload) w_next = ST_HDR0;
      default: w_next = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_count <= 16'd0;
      r_idx   <= '0;
      r_idle  <= '0;
    end else begin
      if (w_accept || !w_loading) r_idle <= '0;
      else                        r_idle <= r_idle + c_IDLE_W'(1);

      if ((r_state == ST_HDR0) && w_accept) r_count[c_HDR_HI_LSB +: 8] <= in_data;
      if ((r_state == ST_HDR1) && w_accept) r_count[c_HDR_LO_LSB +: 8] <= in_data;

      // The final write leaves the index at the last address so a full image does not wrap.
      if (w_write && !w_last) r_idx <= r_idx + ADDR_W'(1);

      if (w_restart) begin
        r_count <= 16'd0;
        r_idx   <= '0;
      end
    end
  end

  assign imem_we   = w_write;
  assign imem_addr = r_idx;
  assign imem_wd   = w_word;
  assign cpu_rst   = (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign err       = (r_state == ST_ERR);

endmodule : imem_loader
`default_nettype wire
